// File: rtl/i2c_mst_arb.sv
// Round-robin arbiter that lends one i2c_master to NREQ requesters and streams
// the owner's bytes into mst_dfifo, handshaking on the master's byte-latched edge.
module i2c_mst_arb #(
  parameter int NREQ = 2,
  parameter int LW   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LW-1:0]   len,
  input  logic [NREQ*8-1:0]    wdata,
  output logic [NREQ-1:0]      pop,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic [7:0]           mst_dfifo,
  output logic [7:0]           mst_ctrl,
  input  logic [7:0]           mst_status
);
  localparam int SW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, ARB, XFER, DRAIN, FIN} state_t;

  state_t                  state, state_d;
  logic [SW-1:0]           sel, sel_d, rr, rr_d, pick;
  logic [LW-1:0]           rem, rem_d;
  logic                    nack, nack_d, st7_q, ctrl7, ctrl7_d, found;
  logic [NREQ-1:0]         pop_d, gnt_d, done_d, err_d;
  logic [7:0]              dfifo_d;
  logic [NREQ-1:0][LW-1:0] len_a;
  logic [NREQ-1:0][7:0]    wdata_a;
  logic                    take, nack_in, busy;
  logic                    unused_status;

  assign len_a         = len;
  assign wdata_a       = wdata;
  assign take          = mst_status[7] & ~st7_q;
  assign nack_in       = mst_status[6];
  assign busy          = mst_status[5];
  assign unused_status = ^mst_status[4:0];
  assign mst_ctrl      = {ctrl7, 7'h00};

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] p, input int k);
    int t;
    t = int'(p) + k;
    if (t >= NREQ) t = t - NREQ;
    return t[SW-1:0];
  endfunction

  // first requester at or after the round-robin pointer
  always_comb begin
    pick  = rr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[wrap_inc(rr, k)]) begin
        pick  = wrap_inc(rr, k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    sel_d   = sel;
    rr_d    = rr;
    rem_d   = rem;
    nack_d  = nack;
    pop_d   = '0;
    gnt_d   = gnt;
    done_d  = '0;
    err_d   = '0;
    dfifo_d = mst_dfifo;
    ctrl7_d = ctrl7;
    case (state)
      IDLE: begin
        if (|req) begin
          sel_d        = pick;
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          nack_d       = 1'b0;
          state_d      = ARB;
        end
      end
      ARB: begin
        if (len_a[sel] == '0) begin
          err_d[sel] = 1'b1;
          gnt_d      = '0;
          rr_d       = wrap_inc(sel, 1);
          state_d    = IDLE;
        end else begin
          dfifo_d    = wdata_a[sel];
          pop_d[sel] = 1'b1;
          rem_d      = len_a[sel] - LW'(1);
          ctrl7_d    = 1'b1;
          state_d    = XFER;
        end
      end
      XFER: begin
        // a NACK overrides a simultaneous take: nothing more is fetched
        if (nack_in) begin
          ctrl7_d = 1'b0;
          nack_d  = 1'b1;
          state_d = DRAIN;
        end else if (take) begin
          if (rem != '0) begin
            dfifo_d    = wdata_a[sel];
            pop_d[sel] = 1'b1;
            rem_d      = rem - LW'(1);
          end else begin
            ctrl7_d = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (nack_in) nack_d = 1'b1;
        if (!busy) state_d = FIN;
      end
      FIN: begin
        if (nack) err_d[sel]  = 1'b1;
        else      done_d[sel] = 1'b1;
        gnt_d   = '0;
        rr_d    = wrap_inc(sel, 1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      sel       <= '0;
      rr        <= '0;
      rem       <= '0;
      nack      <= 1'b0;
      st7_q     <= 1'b0;
      pop       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      mst_dfifo <= 8'h00;
      ctrl7     <= 1'b0;
    end else begin
      state     <= state_d;
      sel       <= sel_d;
      rr        <= rr_d;
      rem       <= rem_d;
      nack      <= nack_d;
      st7_q     <= mst_status[7];
      pop       <= pop_d;
      gnt       <= gnt_d;
      done      <= done_d;
      err       <= err_d;
      mst_dfifo <= dfifo_d;
      ctrl7     <= ctrl7_d;
    end
  end
endmodule

// File: tb/tb_i2c_mst_arb.sv
// Directed bench for i2c_mst_arb: two byte-stream requesters plus a simple
// behavioural i2c_master that latches bytes and can NACK a chosen byte.
module tb_i2c_mst_arb;
  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req;
  logic [7:0]  len;
  logic [15:0] wdata;
  logic [1:0]  pop, gnt, done, err;
  logic [7:0]  mst_dfifo, mst_ctrl, mst_status;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbl [2][16];
  logic [3:0] idx [2];
  int         pops [2];
  int         dones [2];
  int         errs [2];
  logic       clr;
  logic [1:0] gnt_prev;
  logic [1:0] glog [$];
  logic [7:0] cap [$];

  i2c_mst_arb #(.NREQ(2), .LW(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .len(len), .wdata(wdata),
    .pop(pop), .gnt(gnt), .done(done), .err(err),
    .mst_dfifo(mst_dfifo), .mst_ctrl(mst_ctrl), .mst_status(mst_status)
  );

  always #5 clk = ~clk;

  assign wdata = {tbl[1][idx[1]], tbl[0][idx[0]]};

  // requester model: advance to the next byte on pop; log pulses and grants
  always @(posedge clk) begin
    if (clr) begin
      idx[0] <= 4'd0; idx[1] <= 4'd0;
      for (int i = 0; i < 2; i++) begin pops[i] = 0; dones[i] = 0; errs[i] = 0; end
      glog.delete();
      gnt_prev = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pop[i]) begin idx[i] <= idx[i] + 4'd1; pops[i]++; end
        if (done[i]) dones[i]++;
        if (err[i]) errs[i]++;
      end
      if (gnt != 2'b00 && gnt_prev == 2'b00) glog.push_back(gnt);
      gnt_prev = gnt;
    end
  end

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      checks++;
      assert ($onehot0(gnt)) else begin
        errors++;
        $error("FAIL gnt_onehot obs=%b exp=onehot0", gnt);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cap.delete();
  endtask

  // behavioural master: latch each presented byte, pulse byte-latched, NACK byte nack_at
  task automatic master_serve(input int nack_at);
    int n = 0;
    int guard = 0;
    while (mst_ctrl[7] !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    chk("ctrl7_rise", {31'd0, mst_ctrl[7]}, 32'd1);
    if (mst_ctrl[7] !== 1'b1) return;
    mst_status[5] = 1'b1;
    @(negedge clk);
    while (mst_ctrl[7] === 1'b1 && n < 20) begin
      n++;
      cap.push_back(mst_dfifo);
      mst_status[7] = 1'b1;
      if (n == nack_at) mst_status[6] = 1'b1;
      @(negedge clk);
      mst_status[7] = 1'b0;
      mst_status[6] = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    mst_status[5] = 1'b0;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    do_clr();
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      tbl[0][k] = 8'h5A + 8'(2 * k);
      tbl[1][k] = 8'hA0 + 8'(k);
    end
    rstn = 1'b0; req = 2'b00; len = 8'h00; mst_status = 8'h00; clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pop", pop, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dfifo", mst_dfifo, 8'h00);
    chk("rst_ctrl", mst_ctrl, 8'h00);
    rstn = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    // T1: single 4-byte write from requester 0
    len = {4'd0, 4'd4}; req = 2'b01;
    @(negedge clk); req = 2'b00;
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_ctrl_pre", mst_ctrl, 8'h00);
    @(negedge clk);
    chk("t1_ctrl_up", mst_ctrl, 8'h80);
    chk("t1_pop0", pop, 2'b01);
    chk("t1_dfifo0", mst_dfifo, 8'h5A);
    master_serve(0);
    repeat (2) @(negedge clk);
    chk("t1_done", done, 2'b01);
    chk("t1_gnt_off", gnt, 2'b00);
    repeat (2) @(negedge clk);
    chk("t1_dones", dones[0], 1);
    chk("t1_pops", pops[0], 4);
    chk("t1_ctrl_end", mst_ctrl, 8'h00);
    chk("t1_ncap", cap.size(), 4);
    chk("t1_b0", cap[0], 8'h5A);
    chk("t1_b1", cap[1], 8'h5C);
    chk("t1_b2", cap[2], 8'h5E);
    chk("t1_b3", cap[3], 8'h60);

    // T2: simultaneous requests after reset, two bytes each
    reset_dut();
    len = {4'd2, 4'd2}; req = 2'b11;
    master_serve(0);
    master_serve(0);
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk("t2_ngnt", glog.size(), 2);
    chk("t2_first", glog[0], 2'b01);
    chk("t2_second", glog[1], 2'b10);
    chk("t2_pops0", pops[0], 2);
    chk("t2_pops1", pops[1], 2);
    chk("t2_dones0", dones[0], 1);
    chk("t2_dones1", dones[1], 1);
    chk("t2_ncap", cap.size(), 4);
    chk("t2_b1", cap[1], 8'h5C);
    chk("t2_b2", cap[2], 8'hA0);
    chk("t2_b3", cap[3], 8'hA1);

    // T3: requester 1, 3 bytes, NACK on byte 2
    do_clr();
    len = {4'd3, 4'd0}; req = 2'b10;
    @(negedge clk); req = 2'b00;
    chk("t3_gnt", gnt, 2'b10);
    master_serve(2);
    chk("t3_ctrl_drop", mst_ctrl, 8'h00);
    repeat (2) @(negedge clk);
    chk("t3_err", err, 2'b10);
    chk("t3_done", done, 2'b00);
    repeat (2) @(negedge clk);
    chk("t3_pops", pops[1], 2);
    chk("t3_errs", errs[1], 1);
    chk("t3_dones", dones[1], 0);

    // T4: zero length request
    do_clr();
    len = {4'd0, 4'd0}; req = 2'b01;
    @(negedge clk); req = 2'b00;
    chk("t4_gnt", gnt, 2'b01);
    @(negedge clk);
    chk("t4_err", err, 2'b01);
    chk("t4_gnt_off", gnt, 2'b00);
    chk("t4_ctrl", mst_ctrl, 8'h00);
    chk("t4_pop", pop, 2'b00);
    repeat (3) @(negedge clk);
    chk("t4_pops", pops[0], 0);
    chk("t4_errs", errs[0], 1);

    // T5: req0 held, req1 joins mid-transfer -> 0,1,0
    do_clr();
    len = {4'd1, 4'd2}; req = 2'b01;
    repeat (2) @(negedge clk);
    req = 2'b11;
    master_serve(0);
    master_serve(0);
    master_serve(0);
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk("t5_ngnt", glog.size(), 3);
    chk("t5_g0", glog[0], 2'b01);
    chk("t5_g1", glog[1], 2'b10);
    chk("t5_g2", glog[2], 2'b01);
    chk("t5_pops0", pops[0], 4);
    chk("t5_pops1", pops[1], 1);
    chk("t5_dones0", dones[0], 2);

    // T6: async reset in the middle of a 4-byte transfer
    do_clr();
    len = {4'd0, 4'd4}; req = 2'b01;
    @(negedge clk); req = 2'b00;
    @(negedge clk);
    @(negedge clk); mst_status = 8'hA0;
    @(negedge clk); mst_status = 8'h20;
    @(negedge clk);
    chk("t6_mid_dfifo", mst_dfifo, 8'h5C);
    chk("t6_mid_gnt", gnt, 2'b01);
    rstn = 1'b0; mst_status = 8'h00;
    #1;
    chk("t6_rst_ctrl", mst_ctrl, 8'h00);
    chk("t6_rst_gnt", gnt, 2'b00);
    chk("t6_rst_dfifo", mst_dfifo, 8'h00);
    chk("t6_rst_pop", pop, 2'b00);
    chk("t6_rst_done", {done, err}, 4'h0);
    @(negedge clk);
    rstn = 1'b1;
    do_clr();
    req = 2'b01;
    @(negedge clk); req = 2'b00;
    @(negedge clk);
    chk("t6_restart_dfifo", mst_dfifo, 8'h5A);
    chk("t6_restart_pop", pop, 2'b01);
    master_serve(0);
    repeat (4) @(negedge clk);
    chk("t6_dones", dones[0], 1);
    chk("t6_pops", pops[0], 4);
    chk("t6_ncap", cap.size(), 4);
    chk("t6_b3", cap[3], 8'h60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
